mem_port_arbiter: RTL and testbench

- Shares one memory port between two requesters:
  - the instruction-fetch port (read only);
  - the data load/store port (read/write).
- Lets the core's fetch and MEM stages use one combined instruction/data memory in the SOPC.
- Sits between the openmips core and the memory.
- Issues one registered access at a time, returns read data, and pulses a one-cycle ack to the winning requester.

---
 rtl/mem_port_arbiter_pkg.sv | 12 +
 rtl/mem_arb_pick.sv | 20 ++
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 tb/tb_mem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state encodings, port IDs, bus constants for the fetch/data memory arbiter.
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ACK} state_t;
    localparam logic PORT_IF       = 1'b0;
    localparam logic PORT_D        = 1'b1;
    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam int   ADDR_W_DEF    = 32;
    localparam int   DATA_W_DEF    = 32;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection between fetch (bit 0) and data (bit 1).
// Ports: i_eligible (req vector), i_last_grant -> o_grant_valid, o_grant_id.
// Macro MEM_ARB_RR_EN: round robin on tie; otherwise data always wins a tie.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] i_eligible,
    input  logic       i_last_grant,
    output logic       o_grant_valid,
    output logic       o_grant_id
);
    assign o_grant_valid = |i_eligible;
`ifdef MEM_ARB_RR_EN
    assign o_grant_id = &i_eligible ? ~i_last_grant : i_eligible[PORT_D];
`else
    logic w_unused;
    assign w_unused   = i_last_grant;
    assign o_grant_id = i_eligible[PORT_D];
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (read only) and data load/store.
// Ports: if_* fetch requester, d_* data requester, mem_* registered memory command, busy_o state != IDLE.
// Macro MEM_ARB_RR_EN: round-robin tie-break instead of fixed data priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_data_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [SEL_W-1:0]  d_sel_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [SEL_W-1:0]  mem_sel_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);
    state_t            r_state, w_next;
    logic              r_win, r_last_grant;
    logic              r_if_ack, r_d_ack, r_mem_ce, r_mem_we;
    logic [DATA_W-1:0] r_if_data, r_d_rdata, r_mem_wdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [SEL_W-1:0]  r_mem_sel;
    logic [1:0]        w_elig;
    logic              w_gnt_valid, w_gnt_id;

    // In ACK the just-acked port is masked so a still-held req is not reissued back to back.
    always_comb begin
        w_elig = r_state == ST_IDLE ? {d_req_i, if_req_i} :
                 r_state == ST_ACK  ? {d_req_i, if_req_i} & (r_win ? 2'b01 : 2'b10) : 2'b00;
        w_next = r_state == ST_ACCESS ? ST_ACK : w_gnt_valid ? ST_ACCESS : ST_IDLE;
    end

    mem_arb_pick u_pick (
        .i_eligible    (w_elig),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_gnt_valid),
        .o_grant_id    (w_gnt_id)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_win        <= PORT_IF;
            r_last_grant <= PORT_D;
            r_if_ack     <= 1'b0;
            r_d_ack      <= 1'b0;
            r_mem_ce     <= CHIP_DISABLE;
            r_mem_we     <= WRITE_DISABLE;
            r_mem_addr   <= '0;
            r_mem_sel    <= '0;
            r_mem_wdata  <= '0;
            r_if_data    <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_state  <= w_next;
            r_if_ack <= r_state == ST_ACCESS && r_win == PORT_IF;
            r_d_ack  <= r_state == ST_ACCESS && r_win == PORT_D;
            if (w_gnt_valid) begin
                r_win        <= w_gnt_id;
                r_last_grant <= w_gnt_id;
                r_mem_ce     <= CHIP_ENABLE;
                r_mem_we     <= w_gnt_id ? d_we_i : WRITE_DISABLE;
                r_mem_addr   <= w_gnt_id ? d_addr_i : if_addr_i;
                r_mem_sel    <= w_gnt_id ? d_sel_i : '1;
                r_mem_wdata  <= w_gnt_id ? d_wdata_i : '0;
            end else if (r_state == ST_ACCESS) begin
                r_mem_ce <= CHIP_DISABLE;
                r_mem_we <= WRITE_DISABLE;
                if (!r_mem_we && r_win == PORT_D) r_d_rdata <= mem_rdata_i;
                if (!r_mem_we && r_win == PORT_IF) r_if_data <= mem_rdata_i;
            end
        end
    end

    assign if_ack_o    = r_if_ack;
    assign if_data_o   = r_if_data;
    assign d_ack_o     = r_d_ack;
    assign d_rdata_o   = r_d_rdata;
    assign mem_ce_o    = r_mem_ce;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_sel_o   = r_mem_sel;
    assign mem_wdata_o = r_mem_wdata;
    assign busy_o      = r_state != ST_IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter (default build, fixed data priority).
module tb_mem_port_arbiter;
    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_i = 1'b0, d_req_i = 1'b0, d_we_i = 1'b0;
    logic [31:0] if_addr_i = '0, d_addr_i = '0, d_wdata_i = '0;
    logic [3:0]  d_sel_i = '0;
    logic        if_ack_o, d_ack_o, mem_ce_o, mem_we_o, busy_o;
    logic [31:0] if_data_o, d_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem [0:63];
    txn_t        cmd_q[$], ack_q[$];
    int          n_cmp = 0, n_bad = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_data_o(if_data_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_sel_i(d_sel_i),
        .d_wdata_i(d_wdata_i), .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    assign mem_rdata_i = mem[mem_addr_o[7:2]];

    always @(posedge clk)
        if (mem_ce_o && mem_we_o)
            for (int b = 0; b < 4; b++)
                if (mem_sel_o[b]) mem[mem_addr_o[7:2]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];

    function automatic txn_t mk(input logic port, input logic we, input logic [31:0] addr,
                                input logic [3:0] sel, input logic [31:0] wdata, input logic [31:0] rdata);
        txn_t t;
        t.port = port; t.we = we; t.addr = addr; t.sel = sel; t.wdata = wdata; t.rdata = rdata;
        return t;
    endfunction

    // Scoreboard: every memory command and every ack is matched against the queued expectation.
    always @(negedge clk) begin
        txn_t t;
        if (mem_ce_o) begin
            n_cmp++;
            if (cmd_q.size() == 0) begin
                n_bad++;
                $display("FAIL spurious_cmd: got addr=%h we=%b, required no access", mem_addr_o, mem_we_o);
            end else begin
                t = cmd_q.pop_front();
                if ({mem_we_o, mem_addr_o, mem_sel_o} !== {t.we, t.addr, t.sel} || (t.we && mem_wdata_o !== t.wdata)) begin
                    n_bad++;
                    $display("FAIL cmd: got we=%b addr=%h sel=%b wdata=%h, required we=%b addr=%h sel=%b wdata=%h",
                             mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o, t.we, t.addr, t.sel, t.wdata);
                end
            end
        end
        if (if_ack_o || d_ack_o) begin
            n_cmp++;
            if (ack_q.size() == 0) begin
                n_bad++;
                $display("FAIL spurious_ack: got if_ack=%b d_ack=%b, required none", if_ack_o, d_ack_o);
            end else begin
                t = ack_q.pop_front();
                if ({d_ack_o, if_ack_o} !== (t.port ? 2'b10 : 2'b01) ||
                    (!t.we && (t.port ? d_rdata_o : if_data_o) !== t.rdata)) begin
                    n_bad++;
                    $display("FAIL ack: got d_ack=%b if_ack=%b if_data=%h d_rdata=%h, required port=%b data=%h",
                             d_ack_o, if_ack_o, if_data_o, d_rdata_o, t.port, t.rdata);
                end
            end
        end
    end

    task automatic wait_ack(input string name);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (if_ack_o || d_ack_o) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL %s_timeout: got no ack in 10 cycles, required ack", name);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({if_ack_o, d_ack_o, mem_ce_o, mem_we_o, busy_o, mem_addr_o, mem_sel_o, mem_wdata_o, if_data_o, d_rdata_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ce=%b busy=%b addr=%h data=%h, required all zero", mem_ce_o, busy_o, mem_addr_o, if_data_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single_fetch;
        cmd_q.push_back(mk(1'b0, 1'b0, 32'h10, 4'hf, 32'h0, 32'h0));
        ack_q.push_back(mk(1'b0, 1'b0, 32'h10, 4'hf, 32'h0, 32'h3401_1100));
        @(negedge clk);
        if_req_i = 1'b1; if_addr_i = 32'h10;
        @(negedge clk);
        n_cmp++;
        if ({mem_ce_o, if_ack_o, busy_o} !== 3'b101) begin
            n_bad++;
            $display("FAIL fetch_cmd_cycle: got ce=%b ack=%b busy=%b, required 1 0 1", mem_ce_o, if_ack_o, busy_o);
        end
        @(negedge clk);
        n_cmp++;
        if ({mem_ce_o, if_ack_o, if_data_o} !== {2'b01, 32'h3401_1100}) begin
            n_bad++;
            $display("FAIL fetch_ack_cycle: got ce=%b ack=%b data=%h, required 0 1 34011100", mem_ce_o, if_ack_o, if_data_o);
        end
        if_req_i = 1'b0; if_addr_i = 32'h20;
        @(negedge clk);
        n_cmp++;
        if ({mem_ce_o, if_ack_o, busy_o, if_data_o} !== {3'b000, 32'h3401_1100}) begin
            n_bad++;
            $display("FAIL fetch_hold: got ce=%b ack=%b busy=%b data=%h, required 0 0 0 34011100", mem_ce_o, if_ack_o, busy_o, if_data_o);
        end
    endtask

    task automatic test_data_write;
        cmd_q.push_back(mk(1'b1, 1'b0, 32'h40, 4'hf, 32'h0, 32'h0));
        ack_q.push_back(mk(1'b1, 1'b0, 32'h40, 4'hf, 32'h0, 32'h1122_3344));
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h40; d_sel_i = 4'hf;
        wait_ack("data_read");
        d_req_i = 1'b0;
        cmd_q.push_back(mk(1'b1, 1'b1, 32'h40, 4'b0011, 32'hDEAD_BEEF, 32'h0));
        ack_q.push_back(mk(1'b1, 1'b1, 32'h40, 4'b0011, 32'hDEAD_BEEF, 32'h0));
        @(negedge clk);
        d_req_i = 1'b1; d_we_i = 1'b1; d_sel_i = 4'b0011; d_wdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        d_we_i = 1'b0; d_wdata_i = 32'h0; d_addr_i = 32'h80;
        wait_ack("data_write");
        d_req_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (d_rdata_o !== 32'h1122_3344) begin
            n_bad++;
            $display("FAIL write_rdata_unchanged: got %h, required 11223344", d_rdata_o);
        end
        n_cmp++;
        if (mem[16] !== 32'h1122_BEEF) begin
            n_bad++;
            $display("FAIL write_bytes: got mem=%h, required 1122beef", mem[16]);
        end
        cmd_q.push_back(mk(1'b1, 1'b0, 32'h40, 4'hf, 32'h0, 32'h0));
        ack_q.push_back(mk(1'b1, 1'b0, 32'h40, 4'hf, 32'h0, 32'h1122_BEEF));
        d_req_i = 1'b1; d_addr_i = 32'h40; d_sel_i = 4'hf;
        wait_ack("data_readback");
        d_req_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int acks = 0;
        for (int k = 0; k < 3; k++) begin
            cmd_q.push_back(mk(1'b1, 1'b0, 32'h20, 4'hf, 32'h0, 32'h0));
            ack_q.push_back(mk(1'b1, 1'b0, 32'h20, 4'hf, 32'h0, 32'hA5A5_0020));
            cmd_q.push_back(mk(1'b0, 1'b0, 32'h10, 4'hf, 32'h0, 32'h0));
            ack_q.push_back(mk(1'b0, 1'b0, 32'h10, 4'hf, 32'h0, 32'h3401_1100));
        end
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h20; d_sel_i = 4'hf;
        if_req_i = 1'b1; if_addr_i = 32'h10;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            acks += int'(if_ack_o) + int'(d_ack_o);
            n_cmp++;
            if ({busy_o, if_ack_o | d_ack_o} !== {1'b1, i % 2 == 0}) begin
                n_bad++;
                $display("FAIL tie_cycle%0d: got busy=%b ack=%b, required 1 %b", i, busy_o, if_ack_o | d_ack_o, i % 2 == 0);
            end
        end
        d_req_i = 1'b0; if_req_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({acks, busy_o} !== {32'd6, 1'b0}) begin
            n_bad++;
            $display("FAIL tie_total: got acks=%0d busy=%b, required 6 0", acks, busy_o);
        end
    endtask

    task automatic test_held_req;
        int first = -1, n = 0;
        for (int k = 0; k < 2; k++) begin
            cmd_q.push_back(mk(1'b0, 1'b0, 32'h10, 4'hf, 32'h0, 32'h0));
            ack_q.push_back(mk(1'b0, 1'b0, 32'h10, 4'hf, 32'h0, 32'h3401_1100));
        end
        if_req_i = 1'b1; if_addr_i = 32'h10;
        for (int i = 0; i < 12 && n < 2; i++) begin
            @(negedge clk);
            if (if_ack_o && mem_ce_o) begin
                n_cmp++; n_bad++;
                $display("FAIL held_ce_in_ack: got ce=1 during own ack, required 0");
            end
            if (if_ack_o) begin
                n++;
                if (n == 1) first = i;
                else begin
                    n_cmp++;
                    if (i - first < 2) begin
                        n_bad++;
                        $display("FAIL held_spacing: got %0d cycles, required >= 2", i - first);
                    end
                end
            end
        end
        if_req_i = 1'b0;
        n_cmp++;
        if (n != 2) begin
            n_bad++;
            $display("FAIL held_count: got %0d acks, required 2", n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access;
        cmd_q.push_back(mk(1'b0, 1'b0, 32'h10, 4'hf, 32'h0, 32'h0));
        if_req_i = 1'b1; if_addr_i = 32'h10;
        @(negedge clk);
        n_cmp++;
        if (mem_ce_o !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_setup: got ce=%b, required 1", mem_ce_o);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({mem_ce_o, mem_we_o, if_ack_o, d_ack_o, busy_o, mem_addr_o, if_data_o} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs: got ce=%b busy=%b addr=%h data=%h, required all zero", mem_ce_o, busy_o, mem_addr_o, if_data_o);
        end
        @(negedge clk);
        n_cmp++;
        if ({if_ack_o, mem_ce_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_mid_no_ack: got ack=%b ce=%b, required 0 0", if_ack_o, mem_ce_o);
        end
        cmd_q.push_back(mk(1'b0, 1'b0, 32'h10, 4'hf, 32'h0, 32'h0));
        ack_q.push_back(mk(1'b0, 1'b0, 32'h10, 4'hf, 32'h0, 32'h3401_1100));
        rst = 1'b1;
        wait_ack("rst_mid_refetch");
        if_req_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (if_data_o !== 32'h3401_1100) begin
            n_bad++;
            $display("FAIL rst_mid_refetch_data: got %h, required 34011100", if_data_o);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4]  = 32'h3401_1100;
        mem[8]  = 32'hA5A5_0020;
        mem[16] = 32'h1122_3344;
        test_reset;
        test_single_fetch;
        test_data_write;
        test_back_to_back;
        test_held_req;
        test_reset_mid_access;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (cmd_q.size() != 0 || ack_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d cmds %0d acks pending, required 0 0", cmd_q.size(), ack_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
